audio_stream_ctrl: RTL

- Controller between the audio sources and the 48-bit sample FIFO that feeds i2s_master.
- Selects one of two sample sources (mono synthesiser, e.g. sine_generator, or a stereo source, e.g. CPU stream), or generates silence, and writes samples into the FIFO.
- Prefills the FIFO before enabling the I2S master, and drains it cleanly on stop.
- Counts underruns caused by the I2S master reading an empty FIFO.

---
 rtl/audio_pkg.sv | 18 +
 rtl/audio_stream_ctrl_sat_counter.sv | 20 ++
 rtl/audio_stream_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared constants for the audio stream controller: FSM states, source selects
// and the default per-channel sample width.
package audio_pkg;

    localparam int unsigned AUDIO_BW = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam logic [1:0] SEL_SILENCE = 2'd0;
    localparam logic [1:0] SEL_SRC0    = 2'd1;
    localparam logic [1:0] SEL_SRC1    = 2'd2;

endpackage

// File: rtl/audio_stream_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/audio_stream_ctrl.sv
// Feeds the I2S sample FIFO from a mono source, a stereo source or silence,
// with prefill before enabling playback, clean drain on stop and underrun counting.
module audio_stream_ctrl
    import audio_pkg::*;
#(
    parameter int unsigned BW      = AUDIO_BW,
    parameter int unsigned LGFLEN  = 4,
    parameter int unsigned PREFILL = 8,
    parameter int unsigned CNTW    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic [1:0]        cfg_sel,
    input  logic [BW-1:0]     src0_data,
    input  logic              src0_valid,
    output logic              src0_ready,
    input  logic [2*BW-1:0]   src1_data,
    input  logic              src1_valid,
    output logic              src1_ready,
    output logic [2*BW-1:0]   fifo_wr_data,
    output logic              fifo_wr,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic [LGFLEN:0]   fifo_fill,
    input  logic              fifo_rd,
    output logic              i2s_run,
    output logic              busy,
    output logic              underrun,
    output logic [CNTW-1:0]   underrun_cnt
);

    localparam int unsigned DW = 2 * BW;
    localparam int unsigned FW = LGFLEN + 1;
    localparam logic [FW-1:0] PREFILL_LVL = FW'(PREFILL);

    state_t        state;
    logic [1:0]    active_sel;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [DW-1:0] load_data;

    logic streaming;
    logic reg_free;
    logic hs0;
    logic hs1;
    logic silence;
    logic load;
    logic start;
    logic ur_event;

    // Output register is free when empty or when its sample is being accepted now
    assign streaming = (state == ST_PREFILL) || (state == ST_RUN);
    assign reg_free  = !out_valid || !fifo_full;
    assign silence   = (active_sel != SEL_SRC0) && (active_sel != SEL_SRC1);

    assign src0_ready = streaming && (active_sel == SEL_SRC0) && reg_free;
    assign src1_ready = streaming && (active_sel == SEL_SRC1) && reg_free;
    assign hs0        = src0_valid && src0_ready;
    assign hs1        = src1_valid && src1_ready;
    assign load       = streaming && reg_free && (hs0 || hs1 || silence);

    assign start    = (state == ST_IDLE) && cfg_en;
    assign ur_event = (state == ST_RUN) && fifo_rd && fifo_empty;

    assign fifo_wr      = out_valid;
    assign fifo_wr_data = out_data;

    always_comb begin
        load_data = '0;
        if (active_sel == SEL_SRC0) begin
            load_data = {src0_data, src0_data};
        end else if (active_sel == SEL_SRC1) begin
            load_data = src1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            active_sel <= SEL_SILENCE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            i2s_run    <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
            end else if (out_valid && !fifo_full) begin
                out_valid <= 1'b0;
            end

            // Select only changes between samples so a stereo word is never torn
            if (streaming && !hs0 && !hs1) begin
                active_sel <= cfg_sel;
            end

            if (ur_event) begin
                underrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_en) begin
                        state      <= ST_PREFILL;
                        busy       <= 1'b1;
                        active_sel <= cfg_sel;
                        underrun   <= 1'b0;
                    end
                end
                ST_PREFILL: begin
                    if (!cfg_en) begin
                        state   <= ST_DRAIN;
                        i2s_run <= 1'b1;
                    end else if (fifo_fill >= PREFILL_LVL) begin
                        state   <= ST_RUN;
                        i2s_run <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!cfg_en) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !out_valid) begin
                        state   <= ST_IDLE;
                        i2s_run <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W (CNTW)
    ) u_underrun_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .inc (ur_event),
        .cnt (underrun_cnt)
    );

endmodule
